// File: rtl/mux_arbiter_4_to_1_if.sv
// Handshake bundle between four requesters, the arbiter and its sink.
// The arbiter takes the slave view and the environment takes the master view.
interface mux_arbiter_4_to_1_if #(
  parameter int NBits = 32
);
  logic [3:0]       Req_i;
  logic [NBits-1:0] Data_0_i;
  logic [NBits-1:0] Data_1_i;
  logic [NBits-1:0] Data_2_i;
  logic [NBits-1:0] Data_3_i;
  logic             Ready_i;
  logic [1:0]       Selector_o;
  logic [3:0]       Grant_o;
  logic             Valid_o;
  logic [NBits-1:0] Data_o;
  logic [3:0]       Ack_o;
  logic             Busy_o;

  modport slave (
    input  Req_i, Data_0_i, Data_1_i,
    input  Data_2_i, Data_3_i, Ready_i,
    output Selector_o, Grant_o, Valid_o,
    output Data_o, Ack_o, Busy_o
  );

  modport master (
    output Req_i, Data_0_i, Data_1_i,
    output Data_2_i, Data_3_i, Ready_i,
    input  Selector_o, Grant_o, Valid_o,
    input  Data_o, Ack_o, Busy_o
  );
endinterface

// File: rtl/mux_arbiter_4_to_1.sv
// Round-robin 4:1 arbiter with registered mux output.
// Each transfer runs IDLE -> SEND (wait Ready) -> ACK.
module mux_arbiter_4_to_1 #(
  parameter int NBits = 32
) (
  input logic                   clk,
  input logic                   reset,
  mux_arbiter_4_to_1_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_sel;
  logic [3:0]       r_grant;
  logic             r_valid;
  logic [NBits-1:0] r_data;
  logic [3:0]       r_ack;
  logic             r_busy;

  state_t           w_state;
  logic [1:0]       w_last;
  logic [1:0]       w_sel;
  logic [3:0]       w_grant;
  logic             w_valid;
  logic [NBits-1:0] w_data;
  logic [3:0]       w_ack;
  logic             w_busy;

  logic             w_found;
  logic [1:0]       w_pick;
  logic [1:0]       w_idx;
  logic [NBits-1:0] w_mux;

  // Search starts just after the last served requester
  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_idx   = 2'd0;
    for (int i = 1; i < 5; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && bus.Req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_mux = bus.Data_0_i;
    unique case (w_pick)
      2'd0: w_mux = bus.Data_0_i;
      2'd1: w_mux = bus.Data_1_i;
      2'd2: w_mux = bus.Data_2_i;
      2'd3: w_mux = bus.Data_3_i;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_sel   = r_sel;
    w_grant = r_grant;
    w_valid = r_valid;
    w_data  = r_data;
    w_ack   = 4'd0;
    unique case (r_state)
      IDLE: begin
        w_valid = 1'b0;
        w_grant = 4'd0;
        if (w_found) begin
          w_sel   = w_pick;
          w_grant = 4'b0001 << w_pick;
          w_data  = w_mux;
          w_valid = 1'b1;
          w_state = SEND;
        end
      end
      SEND: begin
        if (bus.Ready_i) begin
          w_valid = 1'b0;
          w_grant = 4'd0;
          w_ack   = 4'b0001 << r_sel;
          w_last  = r_sel;
          w_state = ACK;
        end
      end
      ACK: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_valid = 1'b0;
        w_grant = 4'd0;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_grant <= 4'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ack   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_sel   <= w_sel;
      r_grant <= w_grant;
      r_valid <= w_valid;
      r_data  <= w_data;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  assign bus.Selector_o = r_sel;
  assign bus.Grant_o    = r_grant;
  assign bus.Valid_o    = r_valid;
  assign bus.Data_o     = r_data;
  assign bus.Ack_o      = r_ack;
  assign bus.Busy_o     = r_busy;

endmodule
